// File: rtl/instruction_fetch.sv
// instruction_fetch: PC owner and one-entry fetch buffer with valid/ready handshake and redirect flush.
// Define FETCH_PERF_COUNT_EN to add the oAcceptCount/oBubbleCount performance counters.
module instruction_fetch #(
  parameter logic [15:0] RESET_PC = 16'd0
) (
  input  logic        Clock,
  input  logic        Reset,
  output logic [15:0] oAddress,
  input  logic [27:0] iInstruction,
  output logic        oValid,
  input  logic        iReady,
  output logic [27:0] oInstruction,
  output logic [15:0] oPC,
  output logic [3:0]  oOpcode,
  output logic [7:0]  oDest,
  output logic [7:0]  oSrcA,
  output logic [7:0]  oSrcB,
  output logic [15:0] oImm,
  input  logic        iRedirect,
`ifdef FETCH_PERF_COUNT_EN
  input  logic [15:0] iRedirectAddr,
  output logic [15:0] oAcceptCount,
  output logic [15:0] oBubbleCount
`else
  input  logic [15:0] iRedirectAddr
`endif
);
  logic [15:0] pc;
  logic        load;
  assign load     = !oValid || iReady;
  assign oAddress = pc;
  assign oOpcode  = oInstruction[27:24];
  assign oDest    = oInstruction[23:16];
  assign oSrcA    = oInstruction[15:8];
  assign oSrcB    = oInstruction[7:0];
  assign oImm     = oInstruction[15:0];
  // Redirect drops the buffered word but keeps its contents; only valid is cleared.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      pc           <= RESET_PC;
      oValid       <= 1'b0;
      oInstruction <= '0;
      oPC          <= '0;
    end else if (iRedirect) begin
      pc     <= iRedirectAddr;
      oValid <= 1'b0;
    end else if (load) begin
      oInstruction <= iInstruction;
      oPC          <= pc;
      oValid       <= 1'b1;
      pc           <= pc + 16'd1;
    end
  end
`ifdef FETCH_PERF_COUNT_EN
  logic armed;
  // armed skips the first post-reset edge, whose empty buffer is the reset bubble.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      armed        <= 1'b0;
      oAcceptCount <= '0;
      oBubbleCount <= '0;
    end else begin
      armed        <= 1'b1;
      oAcceptCount <= oAcceptCount + 16'(oValid && iReady);
      oBubbleCount <= oBubbleCount + 16'(armed && !oValid);
    end
  end
`endif
endmodule

// File: tb/tb_instruction_fetch.sv
// tb_instruction_fetch: directed self-checking bench for instruction_fetch (default build).
module tb_instruction_fetch;
  logic        Clock = 1'b0;
  logic        Reset, iReady, iRedirect;
  logic [15:0] iRedirectAddr, oAddress, oPC, oImm;
  logic [27:0] iInstruction, oInstruction;
  logic        oValid;
  logic [3:0]  oOpcode;
  logic [7:0]  oDest, oSrcA, oSrcB;
  int compared = 0, mismatched = 0;

  instruction_fetch dut (
    .Clock(Clock), .Reset(Reset), .oAddress(oAddress), .iInstruction(iInstruction),
    .oValid(oValid), .iReady(iReady), .oInstruction(oInstruction), .oPC(oPC),
    .oOpcode(oOpcode), .oDest(oDest), .oSrcA(oSrcA), .oSrcB(oSrcB), .oImm(oImm),
    .iRedirect(iRedirect), .iRedirectAddr(iRedirectAddr)
  );

  always #5 Clock = ~Clock;

  function automatic logic [27:0] rom(input logic [15:0] a);
    return {a[11:0] ^ 12'hA5C, a};
  endfunction

  assign iInstruction = rom(oAddress);

  task automatic step();
    @(posedge Clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_word(input string tag, input logic v, input logic [15:0] pc, input logic [15:0] addr);
    check({tag, " valid"}, 32'(oValid), 32'(v));
    check({tag, " pc"}, 32'(oPC), 32'(pc));
    check({tag, " addr"}, 32'(oAddress), 32'(addr));
    if (v) check({tag, " instr"}, 32'(oInstruction), 32'(rom(pc)));
  endtask

  initial begin
    Reset = 1'b1; iReady = 1'b1; iRedirect = 1'b0; iRedirectAddr = '0;
    step(); step();
    check("rst valid", 32'(oValid), 0);
    check("rst addr", 32'(oAddress), 0);
    check("rst instr", 32'(oInstruction), 0);
    check("rst pc", 32'(oPC), 0);
    check("rst opcode", 32'(oOpcode), 0);
    check("rst imm", 32'(oImm), 0);
    Reset = 1'b0;
    step();
    check_word("first", 1'b1, 16'd0, 16'd1);
    check("first opcode", 32'(oOpcode), 32'hA);
    check("first dest", 32'(oDest), 32'h5C);
    check("first srca", 32'(oSrcA), 32'h00);
    for (int i = 1; i <= 5; i++) begin
      step();
      check_word("stream", 1'b1, 16'(i), 16'(i + 1));
    end
    check("stream srcb", 32'(oSrcB), 32'h05);
    check("stream imm", 32'(oImm), 32'h0005);
    iReady = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      check_word("stall", 1'b1, 16'd5, 16'd6);
    end
    iReady = 1'b1;
    for (int i = 6; i <= 13; i++) begin
      step();
      check_word("resume", 1'b1, 16'(i), 16'(i + 1));
    end
    iRedirect = 1'b1; iRedirectAddr = 16'd10;
    step();
    check_word("redir bubble", 1'b0, 16'd13, 16'd10);
    check("redir hold instr", 32'(oInstruction), 32'(rom(16'd13)));
    iRedirect = 1'b0;
    step();
    check_word("redir target", 1'b1, 16'd10, 16'd11);
    check("redir opcode", 32'(oOpcode), 32'(rom(16'd10) >> 24));
    iReady = 1'b0;
    step();
    check_word("pre-stall", 1'b1, 16'd10, 16'd11);
    iRedirect = 1'b1; iRedirectAddr = 16'd2;
    step();
    check_word("stall redir", 1'b0, 16'd10, 16'd2);
    iRedirect = 1'b0; iReady = 1'b1;
    step();
    check_word("stall redir target", 1'b1, 16'd2, 16'd3);
    iRedirect = 1'b1; iRedirectAddr = 16'd20;
    step();
    check_word("b2b first", 1'b0, 16'd2, 16'd20);
    iRedirectAddr = 16'hFFFF;
    step();
    check_word("b2b second", 1'b0, 16'd2, 16'hFFFF);
    iRedirect = 1'b0;
    step();
    check_word("wrap top", 1'b1, 16'hFFFF, 16'h0000);
    step();
    check_word("wrap zero", 1'b1, 16'h0000, 16'h0001);
    Reset = 1'b1; iRedirect = 1'b1; iRedirectAddr = 16'd7; iReady = 1'b0;
    step();
    check_word("rst+redir", 1'b0, 16'd0, 16'd0);
    check("rst+redir instr", 32'(oInstruction), 0);
    Reset = 1'b0; iRedirect = 1'b0;
    step();
    check_word("load not ready", 1'b1, 16'd0, 16'd1);
    step();
    check_word("stall after rst", 1'b1, 16'd0, 16'd1);
    iReady = 1'b1;
    step();
    check_word("release after rst", 1'b1, 16'd1, 16'd2);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end
endmodule
